// File: rtl/coeff_seq_pkg.sv
// Shared types and constants for the coefficient sequencer.
//   seq_state_e : sequencer FSM states (IDLE, RUN)
//   MODE_*      : encodings of the mode input
package coeff_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SEQ    = 1'b1;

endpackage

// File: rtl/coeff_bank.sv
// Coefficient register file: NUM_COEFF x COEFF_W, one write port, one
// combinational read port, async clear to zero.
//   Clock, GlobalReset_n : clock, async active-low reset
//   wr_en/wr_addr/wr_data: write port; out-of-range addresses are dropped
//   rd_addr              : read index
//   rd_data_c            : combinational read data, zero when out of range
module coeff_bank
  import coeff_seq_pkg::*;
#(
  parameter  int unsigned NUM_COEFF = 11,
  parameter  int unsigned COEFF_W   = 32,
  localparam int unsigned AW        = $clog2(NUM_COEFF)
) (
  input  logic               Clock,
  input  logic               GlobalReset_n,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [COEFF_W-1:0] wr_data,
  input  logic [AW-1:0]      rd_addr,
  output logic [COEFF_W-1:0] rd_data_c
);

  // One extra bit so NUM_COEFF itself is representable when it is 2**AW.
  localparam logic [AW:0] NUM_LIM = (AW+1)'(NUM_COEFF);

  logic [COEFF_W-1:0] mem [NUM_COEFF];
  logic               wr_ok_c;
  logic               rd_ok_c;

  assign wr_ok_c = ({1'b0, wr_addr} < NUM_LIM);
  assign rd_ok_c = ({1'b0, rd_addr} < NUM_LIM);

  // Storage with async clear.
  always_ff @(posedge Clock or negedge GlobalReset_n) begin
    if (!GlobalReset_n) begin
      for (int i = 0; i < int'(NUM_COEFF); i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && wr_ok_c) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read returns pre-edge contents, giving read-before-write to the caller.
  assign rd_data_c = rd_ok_c ? mem[rd_addr] : '0;

endmodule

// File: rtl/coeff_sequencer.sv
// Coefficient sequencer: direct registered select, or index-ordered streaming
// of the whole bank over valid/ready with optional wrap-around.
//   Clock, GlobalReset_n      : clock, async active-low reset
//   wr_en/wr_addr/wr_data     : bank write port
//   mode, coeff_select, start : direct/sequence control (sampled in IDLE)
//   loop                      : wrap after last beat, latched at start
//   coeff_ready               : downstream accepts current beat
//   coeff/coeff_valid/coeff_last/sel_err/busy : registered outputs
module coeff_sequencer
  import coeff_seq_pkg::*;
#(
  parameter  int unsigned NUM_COEFF = 11,
  parameter  int unsigned COEFF_W   = 32,
  localparam int unsigned AW        = $clog2(NUM_COEFF)
) (
  input  logic               Clock,
  input  logic               GlobalReset_n,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [COEFF_W-1:0] wr_data,
  input  logic               mode,
  input  logic [AW-1:0]      coeff_select,
  input  logic               start,
  input  logic               loop,
  input  logic               coeff_ready,
  output logic [COEFF_W-1:0] coeff,
  output logic               coeff_valid,
  output logic               coeff_last,
  output logic               sel_err,
  output logic               busy
);

  localparam logic [AW:0]   NUM_LIM  = (AW+1)'(NUM_COEFF);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_COEFF - 1);

  seq_state_e         state_q;
  logic [AW-1:0]      idx_q;
  logic               loop_q;
  logic [AW-1:0]      idx_inc_c;
  logic [AW-1:0]      rd_addr_c;
  logic [COEFF_W-1:0] rd_data_c;
  logic               sel_oob_c;

  coeff_bank #(
    .NUM_COEFF (NUM_COEFF),
    .COEFF_W   (COEFF_W)
  ) u_bank (
    .Clock         (Clock),
    .GlobalReset_n (GlobalReset_n),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_addr       (rd_addr_c),
    .rd_data_c     (rd_data_c)
  );

  assign idx_inc_c = idx_q + AW'(1);
  assign sel_oob_c = ({1'b0, coeff_select} >= NUM_LIM);

  // Read address is the index that the next registered beat will carry.
  always_comb begin
    rd_addr_c = coeff_select;
    if (state_q == RUN) begin
      rd_addr_c = (idx_q == LAST_IDX) ? '0 : idx_inc_c;
    end else if (mode == MODE_SEQ) begin
      rd_addr_c = '0;
    end
  end

  // FSM, index counter and output register.
  always_ff @(posedge Clock or negedge GlobalReset_n) begin
    if (!GlobalReset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      loop_q      <= 1'b0;
      coeff       <= '0;
      coeff_valid <= 1'b0;
      coeff_last  <= 1'b0;
      sel_err     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          coeff_last <= 1'b0;
          if (mode == MODE_DIRECT) begin
            coeff       <= rd_data_c;
            coeff_valid <= 1'b1;
            sel_err     <= sel_oob_c;
            busy        <= 1'b0;
          end else begin
            sel_err <= 1'b0;
            if (start) begin
              state_q     <= RUN;
              idx_q       <= '0;
              loop_q      <= loop;
              coeff       <= rd_data_c;
              coeff_valid <= 1'b1;
              coeff_last  <= (LAST_IDX == '0);
              busy        <= 1'b1;
            end else begin
              coeff       <= '0;
              coeff_valid <= 1'b0;
              busy        <= 1'b0;
            end
          end
        end
        RUN: begin
          // Without a handshake every output simply holds.
          if (coeff_ready) begin
            if (idx_q != LAST_IDX) begin
              idx_q      <= idx_inc_c;
              coeff      <= rd_data_c;
              coeff_last <= (idx_inc_c == LAST_IDX);
            end else if (loop_q) begin
              idx_q      <= '0;
              coeff      <= rd_data_c;
              coeff_last <= 1'b0;
            end else begin
              state_q     <= IDLE;
              idx_q       <= '0;
              coeff_valid <= 1'b0;
              coeff_last  <= 1'b0;
              busy        <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coeff_sequencer.sv
// Self-checking bench for coeff_sequencer: directed scenarios followed by a
// randomized phase, all checked against a behavioural model of the bank and
// the stream position.
module tb_coeff_sequencer;

  localparam int N  = 11;
  localparam int W  = 32;
  localparam int AW = 4;

  logic          Clock;
  logic          GlobalReset_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          mode;
  logic [AW-1:0] coeff_select;
  logic          start;
  logic          loop;
  logic          coeff_ready;
  logic [W-1:0]  coeff;
  logic          coeff_valid;
  logic          coeff_last;
  logic          sel_err;
  logic          busy;

  coeff_sequencer #(.NUM_COEFF(N), .COEFF_W(W)) dut (
    .Clock         (Clock),
    .GlobalReset_n (GlobalReset_n),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .mode          (mode),
    .coeff_select  (coeff_select),
    .start         (start),
    .loop          (loop),
    .coeff_ready   (coeff_ready),
    .coeff         (coeff),
    .coeff_valid   (coeff_valid),
    .coeff_last    (coeff_last),
    .sel_err       (sel_err),
    .busy          (busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: bank contents plus "which element is on the bus".
  logic [W-1:0] mbank [N];
  bit           m_run;
  int           m_pos;
  bit           m_loop;
  logic [W-1:0] e_coeff;
  bit           e_valid, e_last, e_err, e_busy;

  logic [W-1:0] beat_val [$];
  bit           beat_last[$];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) mbank[i] = '0;
    m_run = 0; m_pos = 0; m_loop = 0;
    e_coeff = '0; e_valid = 0; e_last = 0; e_err = 0; e_busy = 0;
  endfunction

  // Evaluate one clock edge with the inputs currently applied.
  function automatic void model_edge();
    if (!m_run) begin
      e_last = 0;
      if (mode == 1'b0) begin
        e_valid = 1; e_busy = 0;
        if (int'(coeff_select) < N) begin
          e_coeff = mbank[coeff_select]; e_err = 0;
        end else begin
          e_coeff = '0; e_err = 1;
        end
      end else begin
        e_err = 0;
        if (start) begin
          m_run = 1; m_pos = 0; m_loop = loop;
          e_coeff = mbank[0]; e_valid = 1; e_busy = 1;
        end else begin
          e_valid = 0; e_busy = 0;
        end
      end
    end else if (coeff_ready) begin
      if (m_pos < N - 1) m_pos++;
      else if (m_loop) m_pos = 0;
      else begin
        m_run = 0; e_valid = 0; e_busy = 0; e_last = 0;
      end
      if (m_run) begin
        e_coeff = mbank[m_pos];
        e_last  = (m_pos == N - 1);
      end
    end
    if (wr_en && int'(wr_addr) < N) mbank[wr_addr] = wr_data;
  endfunction

  // One cycle: log handshaken beats, clock, update model, compare.
  task automatic tick();
    if (coeff_valid && coeff_ready) begin
      beat_val.push_back(coeff);
      beat_last.push_back(coeff_last);
    end
    @(posedge Clock);
    model_edge();
    #1;
    check("valid", W'(coeff_valid), W'(e_valid));
    check("last",  W'(coeff_last),  W'(e_last));
    check("selerr", W'(sel_err),    W'(e_err));
    check("busy",  W'(busy),        W'(e_busy));
    if (e_valid) check("coeff", coeff, e_coeff);
  endtask

  initial begin
    GlobalReset_n = 1'b0;
    wr_en = 0; wr_addr = '0; wr_data = '0;
    mode = 1'b1; coeff_select = '0; start = 0; loop = 0; coeff_ready = 0;
    model_reset();
    #1;
    check("rst_coeff", coeff, '0);
    check("rst_valid", W'(coeff_valid), '0);
    check("rst_busy",  W'(busy), '0);
    #11;
    GlobalReset_n = 1'b1;

    // Load bank[i] = i.
    for (int i = 0; i < N; i++) begin
      wr_en = 1; wr_addr = AW'(i); wr_data = W'(i);
      tick();
    end
    wr_en = 0;

    // Direct mode selects, including out-of-range.
    mode = 1'b0; coeff_select = 4'd4; tick();
    check("dir4_coeff", coeff, 32'd4);
    check("dir4_err", W'(sel_err), '0);
    coeff_select = 4'd11; tick();
    check("dir11_coeff", coeff, '0);
    check("dir11_err", W'(sel_err), 32'd1);
    coeff_select = 4'd15; tick();
    check("dir15_err", W'(sel_err), 32'd1);
    coeff_select = 4'd10; tick();
    check("dir10_coeff", coeff, 32'd10);
    check("dir10_err", W'(sel_err), '0);

    // Full sequence, no loop, ready always high.
    mode = 1'b1; tick();
    beat_val.delete(); beat_last.delete();
    loop = 0; coeff_ready = 1; start = 1; tick();
    start = 0;
    for (int i = 0; i < N; i++) tick();
    check("seq_nbeats", W'(beat_val.size()), W'(N));
    for (int i = 0; i < beat_val.size(); i++) begin
      check("seq_val", beat_val[i], W'(i));
      check("seq_last", W'(beat_last[i]), W'(i == N - 1));
    end
    check("seq_end_busy", W'(busy), '0);
    check("seq_end_valid", W'(coeff_valid), '0);

    // Backpressure on beat 5.
    beat_val.delete(); beat_last.delete();
    start = 1; tick();
    start = 0;
    for (int k = 0; k < 20 && !(m_run && m_pos == 5); k++) tick();
    check("hold_reach", coeff, 32'd5);
    coeff_ready = 0;
    start = 1; mode = 1'b0;  // ignored while running
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_coeff", coeff, 32'd5);
      check("hold_valid", W'(coeff_valid), 32'd1);
    end
    start = 0; mode = 1'b1;
    coeff_ready = 1; tick();
    check("hold_next", coeff, 32'd6);
    for (int k = 0; k < 20 && busy; k++) tick();
    check("hold_nbeats", W'(beat_val.size()), W'(N));

    // Looping run with a write to index 0 before the wrap.
    loop = 1; start = 1; tick();
    start = 0; loop = 0;
    for (int k = 0; k < 20 && m_pos < 9; k++) tick();
    check("loop_reach", coeff, 32'd9);
    beat_val.delete(); beat_last.delete();
    wr_en = 1; wr_addr = '0; wr_data = 32'hDEAD; tick();
    wr_en = 0;
    tick(); tick(); tick();
    check("loop_nbeats", W'(beat_val.size()), 32'd4);
    if (beat_val.size() == 4) begin
      check("loop_b0", beat_val[0], 32'd9);
      check("loop_b1", beat_val[1], 32'd10);
      check("loop_b1_last", W'(beat_last[1]), 32'd1);
      check("loop_b2", beat_val[2], 32'hDEAD);
      check("loop_b2_last", W'(beat_last[2]), '0);
      check("loop_b3", beat_val[3], 32'd1);
    end

    // Async reset while presenting 7.
    for (int k = 0; k < 20 && m_pos != 7; k++) tick();
    check("abort_reach", coeff, 32'd7);
    #2;
    GlobalReset_n = 1'b0;
    model_reset();
    #1;
    check("abort_coeff", coeff, '0);
    check("abort_valid", W'(coeff_valid), '0);
    check("abort_last",  W'(coeff_last), '0);
    check("abort_busy",  W'(busy), '0);
    check("abort_err",   W'(sel_err), '0);
    #3;
    GlobalReset_n = 1'b1;
    mode = 1'b0; coeff_select = 4'd3; coeff_ready = 0; tick();
    check("cleared3", coeff, '0);

    // Randomized phase.
    for (int k = 0; k < 400; k++) begin
      wr_en        = ($urandom_range(0, 2) == 0);
      wr_addr      = AW'($urandom_range(0, 15));
      wr_data      = $urandom;
      mode         = ($urandom_range(0, 3) != 0);
      coeff_select = AW'($urandom_range(0, 15));
      start        = ($urandom_range(0, 3) == 0);
      loop         = ($urandom_range(0, 3) == 0);
      coeff_ready  = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
